// File: rtl/silife_write_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : silife_write_arbiter_if
// Description : Bundles the source-side (demo/user) write and step signals,
//               the grid-facing outputs and the queue status of the SiLife
//               write arbiter.
//               master = the environment: drives the sources and grid_busy.
//               slave  = the arbiter itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface silife_write_arbiter_if #(
  parameter int ROW_BITS   = 5,
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // Source selection
  logic                demo_mode;

  // Demo pattern generator source
  logic [ROW_BITS-1:0] demo_row_select;
  logic [WIDTH-1:0]    demo_cells;
  logic                demo_wr_en;
  logic                demo_step;

  // User (external) source
  logic [ROW_BITS-1:0] usr_row_select;
  logic [WIDTH-1:0]    usr_cells;
  logic                usr_wr_en;
  logic                usr_step;

  // Grid side
  logic                grid_busy;
  logic [ROW_BITS-1:0] grid_row_select;
  logic [WIDTH-1:0]    grid_cells;
  logic                grid_wr_en;
  logic                grid_step;

  // Status
  logic [LVL_W-1:0]    fifo_level;
  logic                overflow;

  modport master (
    output demo_mode,
    output demo_row_select, demo_cells, demo_wr_en, demo_step,
    output usr_row_select, usr_cells, usr_wr_en, usr_step,
    output grid_busy,
    input  grid_row_select, grid_cells, grid_wr_en, grid_step,
    input  fifo_level, overflow
  );

  modport slave (
    input  demo_mode,
    input  demo_row_select, demo_cells, demo_wr_en, demo_step,
    input  usr_row_select, usr_cells, usr_wr_en, usr_step,
    input  grid_busy,
    output grid_row_select, grid_cells, grid_wr_en, grid_step,
    output fifo_level, overflow
  );

endinterface
`default_nettype wire

// File: rtl/silife_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : silife_write_arbiter
// Description : Selects the demo or user row-write source, queues its writes
//               in a small FIFO and replays them to the SiLife cell grid.
//               Step requests are held back until the queue has drained and
//               the grid is idle, then issued as a single pulse followed by
//               an enforced idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module silife_write_arbiter #(
  parameter int ROW_BITS   = 5,
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STEP_GAP   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  silife_write_arbiter_if.slave  bus
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = ROW_BITS + WIDTH;
  localparam int GAP_W   = (STEP_GAP > 0) ? $clog2(STEP_GAP + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [GAP_W-1:0]     gap_q, gap_d;

  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;

  logic                 pending_q, pending_d;
  logic                 overflow_q, overflow_d;
  logic                 mode_q;

  logic [ROW_BITS-1:0]  row_q, row_d;
  logic [WIDTH-1:0]     cells_q, cells_d;
  logic                 wr_en_q, wr_en_d;
  logic                 step_q, step_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                 w_sel_wr;
  logic                 w_sel_step;
  logic [ENTRY_W-1:0]   w_sel_entry;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_mode_change;
  logic [ENTRY_W-1:0]   w_head;

  // Only the source picked by demo_mode this cycle is looked at at all.
  always_comb begin
    w_sel_wr    = bus.demo_mode ? bus.demo_wr_en : bus.usr_wr_en;
    w_sel_step  = bus.demo_mode ? bus.demo_step  : bus.usr_step;
    w_sel_entry = bus.demo_mode ? {bus.demo_row_select, bus.demo_cells}
                                : {bus.usr_row_select,  bus.usr_cells};
  end

  assign w_full        = (level_q == LVL_W'(FIFO_DEPTH));
  assign w_head        = mem_q[rd_ptr_q];
  assign w_mode_change = (bus.demo_mode != mode_q);

  // A push into a full queue still fits when the head leaves in the same cycle.
  assign w_push = w_sel_wr && (!w_full || w_pop);
  assign w_drop = w_sel_wr &&  w_full && !w_pop;

  // --------------------------------------------------------------------------
  // Drain FSM: pops win over the pending step; a step is followed by a
  // STEP_GAP-cycle hold before anything else is issued.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    w_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((level_q != '0) && !bus.grid_busy) begin
          w_pop = 1'b1;
        end else if ((level_q == '0) && pending_q && !bus.grid_busy) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        gap_d = GAP_W'(STEP_GAP);
        if (STEP_GAP == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Counter reaching zero on this edge releases the hold.
        if (gap_q <= GAP_W'(1)) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Next-state for queue pointers, occupancy, step/overflow flags and outputs.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Issuing the step consumes the pending flag, but a request arriving in
    // that very cycle belongs to the next step and must survive.
    if (state_q == S_STEP) begin
      pending_d = w_sel_step;
    end else begin
      pending_d = pending_q | w_sel_step;
    end

    // Switching source clears the sticky flag; a drop in the same cycle is a
    // fresh event under the new source and still sets it.
    overflow_d = (w_mode_change ? 1'b0 : overflow_q) | w_drop;

    wr_en_d = w_pop;
    step_d  = (state_d == S_STEP);
    row_d   = row_q;
    cells_d = cells_q;
    if (w_pop) begin
      {row_d, cells_d} = w_head;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------

  // Queue storage: data only, validity is carried by the pointers/level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_sel_entry;
    end
  end

  // Control state and registered grid outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gap_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      mode_q     <= 1'b0;
      row_q      <= '0;
      cells_q    <= '0;
      wr_en_q    <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      mode_q     <= bus.demo_mode;
      row_q      <= row_d;
      cells_q    <= cells_d;
      wr_en_q    <= wr_en_d;
      step_q     <= step_d;
    end
  end

  assign bus.grid_row_select = row_q;
  assign bus.grid_cells      = cells_q;
  assign bus.grid_wr_en      = wr_en_q;
  assign bus.grid_step       = step_q;
  assign bus.fifo_level      = level_q;
  assign bus.overflow        = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_silife_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_silife_write_arbiter
// Description : Directed self-checking bench for silife_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_silife_write_arbiter;

  localparam int ROW_BITS   = 5;
  localparam int WIDTH      = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int STEP_GAP   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  silife_write_arbiter_if #(
    .ROW_BITS  (ROW_BITS),
    .WIDTH     (WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) bus ();

  silife_write_arbiter #(
    .ROW_BITS  (ROW_BITS),
    .WIDTH     (WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .STEP_GAP  (STEP_GAP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int overlap = 0;

  logic [12:0] wr_log [$];
  int          wr_cyc [$];
  int          step_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record grid activity mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.grid_wr_en) begin
      wr_log.push_back({bus.grid_row_select, bus.grid_cells});
      wr_cyc.push_back(cyc);
    end
    if (bus.grid_step) step_cyc.push_back(cyc);
    if (bus.grid_wr_en && bus.grid_step) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    wr_cyc.delete();
    step_cyc.delete();
  endtask

  function automatic logic [12:0] wr_at(input int i);
    if (i < wr_log.size()) return wr_log[i];
    return 13'bx;
  endfunction

  function automatic int wcyc_at(input int i);
    if (i < wr_cyc.size()) return wr_cyc[i];
    return -1000;
  endfunction

  function automatic int scyc_at(input int i);
    if (i < step_cyc.size()) return step_cyc[i];
    return -2000;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.demo_mode       = 1'b0;
    bus.demo_row_select = '0;
    bus.demo_cells      = '0;
    bus.demo_wr_en      = 1'b0;
    bus.demo_step       = 1'b0;
    bus.usr_row_select  = '0;
    bus.usr_cells       = '0;
    bus.usr_wr_en       = 1'b0;
    bus.usr_step        = 1'b0;
    bus.grid_busy       = 1'b0;

    // ---- Reset state ----
    tick(3);
    check("rst_level",    32'(bus.fifo_level),      0);
    check("rst_overflow", 32'(bus.overflow),        0);
    check("rst_wr_en",    32'(bus.grid_wr_en),      0);
    check("rst_step",     32'(bus.grid_step),       0);
    check("rst_row",      32'(bus.grid_row_select), 0);
    check("rst_cells",    32'(bus.grid_cells),      0);
    rst_n = 1'b1;
    tick(1);

    // ---- Demo load: 32 back-to-back writes ----
    bus.demo_mode = 1'b1;
    tick(1);
    clear_logs();
    for (int r = 0; r < 32; r++) begin
      bus.demo_wr_en      = 1'b1;
      bus.demo_row_select = 5'(r);
      bus.demo_cells      = 8'hA5 ^ 8'(r);
      tick(1);
      if (r == 0) begin
        check("demo_lat_wr_en0", 32'(bus.grid_wr_en), 0);
        check("demo_lat_level",  32'(bus.fifo_level), 1);
      end
      if (r == 1) begin
        check("demo_lat_wr_en1", 32'(bus.grid_wr_en),      1);
        check("demo_lat_row",    32'(bus.grid_row_select), 0);
        check("demo_lat_cells",  32'(bus.grid_cells),      32'h A5);
      end
      if (r == 16) check("demo_stream_level", 32'(bus.fifo_level), 1);
    end
    bus.demo_wr_en = 1'b0;
    tick(4);
    check("demo_count", 32'(wr_log.size()), 32);
    for (int i = 0; i < 32; i++)
      check($sformatf("demo_entry%0d", i), 32'(wr_at(i)), 32'({5'(i), 8'hA5 ^ 8'(i)}));
    check("demo_throughput", 32'(wcyc_at(31) - wcyc_at(0)), 31);
    check("demo_overflow",   32'(bus.overflow),   0);
    check("demo_level_end",  32'(bus.fifo_level), 0);

    // ---- Backpressure / overflow ----
    bus.demo_mode = 1'b0;
    tick(1);
    clear_logs();
    bus.grid_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.usr_wr_en      = 1'b1;
      bus.usr_row_select = 5'(i + 1);
      bus.usr_cells      = 8'h10 + 8'(i);
      tick(1);
    end
    bus.usr_wr_en = 1'b0;
    tick(1);
    check("bp_level_full", 32'(bus.fifo_level), 4);
    check("bp_overflow",   32'(bus.overflow),   1);
    check("bp_no_wr",      32'(wr_log.size()),  0);
    bus.grid_busy = 1'b0;
    tick(8);
    check("bp_drain_count", 32'(wr_log.size()), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("bp_entry%0d", i), 32'(wr_at(i)), 32'({5'(i + 1), 8'h10 + 8'(i)}));
    check("bp_level_empty",   32'(bus.fifo_level), 0);
    check("bp_overflow_held", 32'(bus.overflow),   1);
    bus.demo_mode = 1'b1;
    tick(1);
    check("mode_clears_overflow", 32'(bus.overflow), 0);

    // ---- Write-before-step, then hold gap ----
    tick(2);
    clear_logs();
    bus.demo_wr_en = 1'b1; bus.demo_step = 1'b1;
    bus.demo_row_select = 5'd10; bus.demo_cells = 8'h61;
    tick(1);
    bus.demo_step = 1'b0;
    bus.demo_row_select = 5'd11; bus.demo_cells = 8'h62;
    tick(1);
    bus.demo_row_select = 5'd12; bus.demo_cells = 8'h63;
    tick(1);
    bus.demo_wr_en = 1'b0;
    tick(1);
    bus.demo_wr_en = 1'b1;
    bus.demo_row_select = 5'd13; bus.demo_cells = 8'h64;
    tick(1);
    bus.demo_wr_en = 1'b0;
    tick(10);
    check("wbs_wr_count",   32'(wr_log.size()),   4);
    check("wbs_step_count", 32'(step_cyc.size()), 1);
    check("wbs_step_after_3rd", 32'(scyc_at(0) - wcyc_at(2)), 1);
    check("wbs_hold_gap",       32'(wcyc_at(3) - scyc_at(0)), 4);
    check("wbs_last_entry", 32'(wr_at(3)), 32'({5'd13, 8'h64}));

    // ---- Step collapse ----
    clear_logs();
    bus.grid_busy = 1'b1;
    bus.demo_step = 1'b1;
    tick(5);
    bus.demo_step = 1'b0;
    tick(3);
    check("collapse_blocked", 32'(step_cyc.size()), 0);
    bus.grid_busy = 1'b0;
    tick(12);
    check("collapse_one_step", 32'(step_cyc.size()), 1);

    // ---- Source select ----
    bus.demo_mode = 1'b0;
    tick(1);
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      bus.demo_wr_en      = (i % 2 == 0);
      bus.demo_step       = (i % 2 == 1);
      bus.demo_row_select = 5'(i + 3);
      bus.demo_cells      = 8'(i * 17);
      tick(1);
    end
    bus.demo_wr_en = 1'b0;
    bus.demo_step  = 1'b0;
    tick(6);
    check("sel_no_wr",    32'(wr_log.size()),   0);
    check("sel_no_step",  32'(step_cyc.size()), 0);
    check("sel_level",    32'(bus.fifo_level),  0);
    bus.usr_wr_en = 1'b1; bus.usr_row_select = 5'd7; bus.usr_cells = 8'h3C;
    tick(1);
    bus.usr_wr_en = 1'b0;
    tick(1);
    check("sel_usr_wr_en", 32'(bus.grid_wr_en),      1);
    check("sel_usr_row",   32'(bus.grid_row_select), 7);
    check("sel_usr_cells", 32'(bus.grid_cells),      32'h3C);

    // ---- Reset mid-operation ----
    tick(3);
    clear_logs();
    bus.grid_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.usr_wr_en      = 1'b1;
      bus.usr_step       = (i == 0);
      bus.usr_row_select = 5'(20 + i);
      bus.usr_cells      = 8'hC0 + 8'(i);
      tick(1);
    end
    bus.usr_wr_en = 1'b0;
    bus.usr_step  = 1'b0;
    tick(1);
    check("mid_level_before", 32'(bus.fifo_level), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_level", 32'(bus.fifo_level),      0);
    check("mid_rst_wr_en", 32'(bus.grid_wr_en),      0);
    check("mid_rst_step",  32'(bus.grid_step),       0);
    check("mid_rst_row",   32'(bus.grid_row_select), 0);
    check("mid_rst_cells", 32'(bus.grid_cells),      0);
    tick(2);
    rst_n = 1'b1;
    bus.grid_busy = 1'b0;
    tick(12);
    check("mid_post_no_wr",   32'(wr_log.size()),   0);
    check("mid_post_no_step", 32'(step_cyc.size()), 0);
    check("never_wr_and_step", 32'(overlap), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/silife_write_arbiter.md
# silife_write_arbiter

Sits directly downstream of the demo pattern generator and upstream of the SiLife cell grid. It selects between the demo source and a user (external) source, buffers their row writes in a small FIFO and replays them to the grid. It also forwards step requests only once all queued writes have landed and the grid is idle, so a pattern load is never torn by a generation step.

## Interface
Parameters:
- ROW_BITS, 5, row address width (32 rows)
- WIDTH, 8, cells per row write
- FIFO_DEPTH, 4, write-queue entries (power of two, ≥2)
- STEP_GAP, 2, idle cycles enforced after each grid_step

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- demo_mode  in  1  1 = accept demo source, 0 = accept user source
- demo_row_select  in  ROW_BITS  demo row address
- demo_cells  in  WIDTH  demo row data
- demo_wr_en  in  1  demo write strobe, one entry per high cycle
- demo_step  in  1  demo step request
- usr_row_select  in  ROW_BITS  user row address
- usr_cells  in  WIDTH  user row data
- usr_wr_en  in  1  user write strobe
- usr_step  in  1  user step request
- grid_busy  in  1  grid computing a generation; no writes/steps accepted
- grid_row_select  out  ROW_BITS  row address to grid (registered)
- grid_cells  out  WIDTH  row data to grid (registered)
- grid_wr_en  out  1  one-cycle write strobe to grid (registered)
- grid_step  out  1  one-cycle step pulse to grid (registered)
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current queue occupancy
- overflow  out  1  sticky: a write was dropped

## Operation
- Source select: only the source chosen by demo_mode is sampled; the other source's wr_en/step are ignored. Selection is combinational per cycle; queued entries are not flushed on a demo_mode change, but overflow clears on any demo_mode change.
- Push: selected wr_en high at a clock edge enqueues {row_select, cells}. Push while full with no pop in the same cycle: entry dropped, overflow set. Push and pop in the same cycle: level unchanged, never overflows.
- Step request: selected step high sets step_pending; repeated requests while pending collapse into one step.
- FSM states IDLE, STEP, HOLD:
  - IDLE: if level>0 and !grid_busy -> pop head, drive grid_wr_en=1 with entry next cycle, stay IDLE. Else if level==0 and step_pending and !grid_busy -> STEP. Writes always take priority over the pending step.
  - STEP: grid_step=1 for exactly this cycle, clear step_pending (a new request in this same cycle re-sets it), -> HOLD with gap counter = STEP_GAP.
  - HOLD: no pops, no steps; counter decrements; at 0 -> IDLE. Pushes continue to be accepted.
- grid_row_select/grid_cells hold last popped value when grid_wr_en=0.
- Row address and data pass unmodified; no arithmetic beyond FIFO pointers (wrap modulo FIFO_DEPTH) and level (0..FIFO_DEPTH).

## Timing
- Reset (async assert, sync-to-clk deassert use): state IDLE, FIFO empty, fifo_level=0, step_pending=0, overflow=0, grid_wr_en=0, grid_step=0, grid_row_select=0, grid_cells=0. Reset mid-drain discards all queued entries and any pending step.
- Write latency: write sampled at edge k -> grid_wr_en high in cycle after edge k+1 (2 cycles) when queue empty and grid idle. Sustained throughput 1 write/cycle.
- Step latency: request at edge k with empty queue, grid idle, state IDLE -> grid_step high after edge k+1.
- grid_busy is sampled at the decision edge; rising grid_busy blocks the next pop/step, never truncates an already-registered strobe.
- grid_wr_en and grid_step never high in the same cycle; min spacing between grid_step pulses is STEP_GAP+1 cycles.

## Test plan
- Demo load: demo_mode=1, 32 back-to-back writes rows 0..31 data 8'hA5^row, grid_busy=0 -> grid sees all 32 in order, first grid_wr_en 2 cycles after first demo_wr_en, overflow=0.
- Backpressure/overflow: grid_busy=1, push 5 user writes (FIFO_DEPTH=4) -> fifo_level=4, overflow=1, 5th dropped; release busy -> exactly 4 writes drained in order.
- Write-before-step: queue 3 writes plus demo_step same cycle as 1st write -> grid_step only after 3rd grid_wr_en; then HOLD of 2 cycles before next pop.
- Step collapse: demo_step high 5 consecutive cycles while grid_busy=1 -> exactly one grid_step after busy drops.
- Source select: demo_mode=0, demo_wr_en/demo_step toggling -> no grid activity; usr write row 7 data 8'h3C -> grid_wr_en with row 7, 8'h3C; toggling demo_mode clears overflow.
- Reset mid-operation: assert rst_n low with 3 queued entries and step pending -> all outputs reset immediately, nothing issued after release.
